// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the MCU bus arbiter: widths, default memory map,
// FSM state codes and the latched master request payload.
package bus_arbiter_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 3;

   // Default memory map: RAM $0000-$01FF, PIO $0200-$020F
   localparam logic [ADDR_W-1:0] RAM_LAST_DEF = 16'h01FF;
   localparam logic [ADDR_W-1:0] PIO_BASE_DEF = 16'h0200;
   localparam logic [ADDR_W-1:0] PIO_LAST_DEF = 16'h020F;

   // Read data returned for addresses outside RAM and PIO
   localparam logic [DATA_W-1:0] UNMAPPED_DATA = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_ACK    = 2'd3
   } state_e;

   // Request captured from the winning master at grant time
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              we;
      logic              re;
   } bus_req_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder for the MCU bus.
// Ports:
//   addr      in  16  bus address
//   sel_ram_c out 1   address falls in RAM ($0000..RAM_LAST)
//   sel_pio_c out 1   address falls in PIO (PIO_BASE..PIO_LAST)
module bus_addr_decode
   import bus_arbiter_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RAM_LAST = RAM_LAST_DEF,
   parameter logic [ADDR_W-1:0] PIO_BASE = PIO_BASE_DEF,
   parameter logic [ADDR_W-1:0] PIO_LAST = PIO_LAST_DEF
) (
   input  logic [ADDR_W-1:0] addr,
   output logic              sel_ram_c,
   output logic              sel_pio_c
);

   // RAM starts at $0000, so only the upper bound needs a compare
   always_comb begin
      sel_ram_c = (addr <= RAM_LAST);
      sel_pio_c = (addr >= PIO_BASE) && (addr <= PIO_LAST);
   end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the MCU memory bus.
// m0 = CPU, m1 = DMA/debug. One transaction in flight: IDLE -> ACCESS ->
// [WAIT] -> ACK -> IDLE. All outputs are registered.
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   req0/1, addr0/1,
//   wdata0/1, we0/1, re0/1   master request inputs (held until ackN)
//   gnt0/1, ack0/1, rdata0/1 master responses
//   bus_addr, bus_wdata,
//   bus_rden, bus_wren,
//   ce_ram, ce_pio           shared bus towards RAM / PIO
//   ram_rdata, pio_rdata     read data from RAM / PIO
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RAM_LAST = RAM_LAST_DEF,
   parameter logic [ADDR_W-1:0] PIO_BASE = PIO_BASE_DEF,
   parameter logic [ADDR_W-1:0] PIO_LAST = PIO_LAST_DEF,
   parameter int unsigned       RD_LAT   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              we0,
   input  logic              we1,
   input  logic              re0,
   input  logic              re1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              bus_rden,
   output logic              bus_wren,
   output logic              ce_ram,
   output logic              ce_pio,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic [DATA_W-1:0] pio_rdata
);

   state_e            state_q, state_d;
   bus_req_t          txn_q, txn_d;
   logic              sel_q, sel_d;       // owner of current transaction (1 = m1)
   logic              last_q, last_d;     // master served most recently
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic              ack0_q, ack0_d, ack1_q, ack1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic              bus_rden_q, bus_rden_d, bus_wren_q, bus_wren_d;
   logic              ce_ram_q, ce_ram_d, ce_pio_q, ce_pio_d;

   logic              win_c;
   bus_req_t          cand_c;
   logic [ADDR_W-1:0] dec_addr_c;
   logic              sel_ram_c, sel_pio_c;
   logic              mapped_c;
   logic [DATA_W-1:0] rd_mux_c;

   // Winner selection: a lone requester wins; on contention the master
   // not served last wins. The decoder sees the candidate in IDLE and the
   // latched address for the rest of the transaction.
   always_comb begin
      win_c      = (req0 && req1) ? ~last_q : req1;
      cand_c     = win_c ? '{addr: addr1, wdata: wdata1, we: we1, re: re1}
                         : '{addr: addr0, wdata: wdata0, we: we0, re: re0};
      dec_addr_c = (state_q == ST_IDLE) ? cand_c.addr : txn_q.addr;
   end

   bus_addr_decode #(
      .RAM_LAST (RAM_LAST),
      .PIO_BASE (PIO_BASE),
      .PIO_LAST (PIO_LAST)
   ) u_decode (
      .addr      (dec_addr_c),
      .sel_ram_c (sel_ram_c),
      .sel_pio_c (sel_pio_c)
   );

   always_comb begin
      mapped_c = sel_ram_c || sel_pio_c;
      rd_mux_c = sel_ram_c ? ram_rdata : (sel_pio_c ? pio_rdata : UNMAPPED_DATA);
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      txn_d       = txn_q;
      sel_d       = sel_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      gnt0_d      = gnt0_q;
      gnt1_d      = gnt1_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_rden_d  = bus_rden_q;
      bus_wren_d  = bus_wren_q;
      ce_ram_d    = ce_ram_q;
      ce_pio_d    = ce_pio_q;

      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               state_d     = ST_ACCESS;
               sel_d       = win_c;
               txn_d       = cand_c;
               gnt0_d      = ~win_c;
               gnt1_d      = win_c;
               bus_addr_d  = cand_c.addr;
               bus_wdata_d = cand_c.wdata;
               // we wins over re; neither or unmapped leaves the bus quiet
               ce_ram_d    = (cand_c.we || cand_c.re) && sel_ram_c;
               ce_pio_d    = (cand_c.we || cand_c.re) && sel_pio_c;
               bus_wren_d  = cand_c.we && mapped_c;
               bus_rden_d  = !cand_c.we && cand_c.re && mapped_c;
            end
         end

         ST_ACCESS: begin
            bus_addr_d  = txn_q.addr;
            bus_wdata_d = txn_q.wdata;
            if (!txn_q.we && txn_q.re) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_W'(RD_LAT);
            end else begin
               state_d    = ST_ACK;
               ack0_d     = ~sel_q;
               ack1_d     = sel_q;
               bus_wren_d = 1'b0;
               bus_rden_d = 1'b0;
               ce_ram_d   = 1'b0;
               ce_pio_d   = 1'b0;
            end
         end

         ST_WAIT: begin
            bus_addr_d  = txn_q.addr;
            bus_wdata_d = txn_q.wdata;
            cnt_d       = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d    = ST_ACK;
               ack0_d     = ~sel_q;
               ack1_d     = sel_q;
               bus_rden_d = 1'b0;
               ce_ram_d   = 1'b0;
               ce_pio_d   = 1'b0;
               if (sel_q) rdata1_d = rd_mux_c;
               else       rdata0_d = rd_mux_c;
            end
         end

         ST_ACK: begin
            state_d = ST_IDLE;
            last_d  = sel_q;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; last_q resets to 1 so m0 wins the first tie
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         txn_q       <= '0;
         sel_q       <= 1'b0;
         last_q      <= 1'b1;
         cnt_q       <= '0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_rden_q  <= 1'b0;
         bus_wren_q  <= 1'b0;
         ce_ram_q    <= 1'b0;
         ce_pio_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         txn_q       <= txn_d;
         sel_q       <= sel_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_rden_q  <= bus_rden_d;
         bus_wren_q  <= bus_wren_d;
         ce_ram_q    <= ce_ram_d;
         ce_pio_q    <= ce_pio_d;
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_rden  = bus_rden_q;
   assign bus_wren  = bus_wren_q;
   assign ce_ram    = ce_ram_q;
   assign ce_pio    = ce_pio_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter. Stimulus pushes the expected
// {master, rdata} of each transaction; a monitor pops one entry per ack.
// A second instance with RD_LAT=3 covers the longer read latency.
module tb_bus_arbiter;
   import bus_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // Main DUT (RD_LAT = 1)
   logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, re0 = 0, re1 = 0;
   logic [15:0] addr0 = 0, addr1 = 0;
   logic [7:0]  wdata0 = 0, wdata1 = 0;
   logic        gnt0, gnt1, ack0, ack1, bus_rden, bus_wren, ce_ram, ce_pio;
   logic [7:0]  rdata0, rdata1, bus_wdata;
   logic [15:0] bus_addr;
   logic [7:0]  ram_rdata = 8'h00, pio_rdata = 8'h00;

   bus_arbiter u_dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1), .re0(re0), .re1(re1),
      .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
      .rdata0(rdata0), .rdata1(rdata1),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rden(bus_rden), .bus_wren(bus_wren),
      .ce_ram(ce_ram), .ce_pio(ce_pio), .ram_rdata(ram_rdata), .pio_rdata(pio_rdata)
   );

   // Second DUT (RD_LAT = 3), only m0 used
   logic        req0_b = 0, re0_b = 0;
   logic [15:0] addr0_b = 0;
   logic        b_gnt0, b_gnt1, b_ack0, b_ack1, b_rden, b_wren, b_ce_ram, b_ce_pio;
   logic [7:0]  b_rdata0, b_rdata1, b_wdata;
   logic [15:0] b_addr;

   bus_arbiter #(.RD_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .req0(req0_b), .req1(1'b0), .addr0(addr0_b), .addr1(16'h0000),
      .wdata0(8'h00), .wdata1(8'h00), .we0(1'b0), .we1(1'b0), .re0(re0_b), .re1(1'b0),
      .gnt0(b_gnt0), .gnt1(b_gnt1), .ack0(b_ack0), .ack1(b_ack1),
      .rdata0(b_rdata0), .rdata1(b_rdata1),
      .bus_addr(b_addr), .bus_wdata(b_wdata), .bus_rden(b_rden), .bus_wren(b_wren),
      .ce_ram(b_ce_ram), .ce_pio(b_ce_pio), .ram_rdata(8'h77), .pio_rdata(8'h00)
   );

   // RAM model: writes on wren, read data appears one cycle after the strobe
   logic [7:0] mem [0:511];
   always @(posedge clk) begin
      if (ce_ram && bus_wren) mem[bus_addr[8:0]] <= bus_wdata;
      if (ce_ram && bus_rden) ram_rdata <= mem[bus_addr[8:0]];
   end

   typedef struct packed { logic id; logic [7:0] rdata; } exp_t;
   exp_t        exp_q[$];
   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic [7:0]  held [2];

   logic [5:0]  s_flags;   // {gnt1, gnt0, ce_ram, ce_pio, wren, rden} in ACCESS
   logic [15:0] s_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic id, input logic rq, input logic [15:0] a,
                        input logic [7:0] d, input logic w, input logic r);
      if (id) begin req1 = rq; addr1 = a; wdata1 = d; we1 = w; re1 = r; end
      else    begin req0 = rq; addr0 = a; wdata0 = d; we0 = w; re0 = r; end
   endtask

   // Monitor: exclusivity every cycle, scoreboard pop on each ack
   always @(negedge clk) begin
      if (rst) begin
         chk("exclusive", {30'd0, gnt0 & gnt1, ce_ram & ce_pio}, 32'd0);
         if (ack0 || ack1) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none", ack0, ack1);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("ack_id", {30'd0, ack1, ack0}, e.id ? 32'd2 : 32'd1);
               chk("rdata", e.id ? rdata1 : rdata0, e.rdata);
            end
         end
      end
   end

   // One transaction: push expectation, hold req until ack, check latency
   // and the ACCESS-cycle bus pattern, then leave the FSM back in IDLE.
   task automatic run_txn(input string name, input logic id, input logic [15:0] a,
                          input logic [7:0] d, input logic w, input logic r,
                          input logic [7:0] rd_val, input int exp_lat, input logic [5:0] exp_flags);
      int  n = 0;
      bit  done = 0;
      exp_t e;
      if (r && !w) held[id] = rd_val;
      e.id = id;
      e.rdata = held[id];
      exp_q.push_back(e);
      drive(id, 1'b1, a, d, w, r);
      while (!done && n < 20) begin
         tick();
         n++;
         if (n == 1) begin
            s_flags = {gnt1, gnt0, ce_ram, ce_pio, bus_wren, bus_rden};
            s_addr  = bus_addr;
         end
         if (id ? ack1 : ack0) done = 1;
      end
      chk({name, "_lat"}, n, exp_lat);
      chk({name, "_access"}, {10'd0, s_flags, s_addr}, {10'd0, exp_flags, a});
      drive(id, 1'b0, a, d, 1'b0, 1'b0);
      tick();
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      #3;
      chk("rst_ctl", {24'd0, gnt0, gnt1, ack0, ack1, bus_rden, bus_wren, ce_ram, ce_pio}, 32'd0);
      chk("rst_data", {rdata1, rdata0, bus_addr}, 32'd0);
      held[0] = 8'h00;
      held[1] = 8'h00;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int acks;
      int rden_cnt;
      int addr_bad;

      apply_reset();

      // Contention right after reset: m0 first, then strict alternation
      for (int k = 0; k < 4; k++) begin
         exp_t e;
         e.id = k[0];
         e.rdata = 8'h00;
         exp_q.push_back(e);
      end
      drive(1'b0, 1'b1, 16'h0020, 8'h11, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 16'h0021, 8'h22, 1'b1, 1'b0);
      acks = 0;
      n = 0;
      while (acks < 4 && n < 40) begin
         tick();
         n++;
         if (ack0 || ack1) acks++;
      end
      chk("alt_acks", acks, 4);
      drive(1'b0, 1'b0, 16'h0020, 8'h11, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 16'h0021, 8'h22, 1'b0, 1'b0);
      tick();

      // Write then read back through RAM
      run_txn("wr_0010", 1'b0, 16'h0010, 8'hA5, 1'b1, 1'b0, 8'h00, 2, 6'b011010);
      run_txn("rd_0010", 1'b0, 16'h0010, 8'h00, 1'b0, 1'b1, 8'hA5, 3, 6'b011001);

      // PIO reads by m1, including the PIO_BASE boundary
      pio_rdata = 8'h3C;
      run_txn("rd_0203", 1'b1, 16'h0203, 8'h00, 1'b0, 1'b1, 8'h3C, 3, 6'b100101);
      run_txn("rd_0200", 1'b1, 16'h0200, 8'h00, 1'b0, 1'b1, 8'h3C, 3, 6'b100101);

      // Unmapped reads: above PIO and in the gap just past PIO_LAST
      run_txn("rd_0300", 1'b0, 16'h0300, 8'h00, 1'b0, 1'b1, 8'hFF, 3, 6'b010000);
      run_txn("rd_0210", 1'b1, 16'h0210, 8'h00, 1'b0, 1'b1, 8'hFF, 3, 6'b100000);

      // we=re=1 behaves as a write
      run_txn("wrd_0005", 1'b0, 16'h0005, 8'h5A, 1'b1, 1'b1, 8'h00, 2, 6'b011010);
      run_txn("rd_0005", 1'b0, 16'h0005, 8'h00, 1'b0, 1'b1, 8'h5A, 3, 6'b011001);

      // RAM_LAST boundary
      run_txn("wr_01ff", 1'b1, 16'h01FF, 8'hC3, 1'b1, 1'b0, 8'h00, 2, 6'b101010);
      run_txn("rd_01ff", 1'b1, 16'h01FF, 8'h00, 1'b0, 1'b1, 8'hC3, 3, 6'b101001);

      // Neither we nor re: no bus activity, rdata1 holds C3
      run_txn("nop_m1", 1'b1, 16'h0010, 8'h00, 1'b0, 1'b0, 8'h00, 2, 6'b100000);

      // RD_LAT=3: ack 5 cycles after req, rden for 4 cycles, address stable
      req0_b = 1'b1;
      addr0_b = 16'h0040;
      re0_b = 1'b1;
      n = 0;
      rden_cnt = 0;
      addr_bad = 0;
      while (n < 20) begin
         tick();
         n++;
         if (b_rden) rden_cnt++;
         if (b_rden && b_addr !== 16'h0040) addr_bad++;
         if (b_ack0) break;
      end
      chk("lat3_ack", n, 5);
      chk("lat3_rden_cycles", rden_cnt, 4);
      chk("lat3_addr_stable", addr_bad, 0);
      chk("lat3_rdata", b_rdata0, 8'h77);
      req0_b = 1'b0;
      re0_b = 1'b0;
      tick();

      // Reset during WAIT: outputs clear at once, no ack; pending req0 served after release
      drive(1'b0, 1'b1, 16'h0010, 8'h00, 1'b0, 1'b1);
      tick();
      tick();
      chk("pre_rst_wait", {29'd0, gnt0, ce_ram, bus_rden}, 32'd7);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_ctl", {24'd0, gnt0, gnt1, ack0, ack1, bus_rden, bus_wren, ce_ram, ce_pio}, 32'd0);
      chk("midrst_data", {rdata1, rdata0, bus_addr}, 32'd0);
      held[0] = 8'h00;
      held[1] = 8'h00;
      tick();
      tick();
      rst = 1'b1;
      run_txn("rd_after_rst", 1'b0, 16'h0010, 8'h00, 1'b0, 1'b1, 8'hA5, 3, 6'b011001);

      repeat (4) tick();
      chk("sb_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
